// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-select adder.
//   ceil_div     : integer ceiling division
//   num_blocks   : carry-select blocks needed for a given width/block size
//   num_stages   : pipeline stages needed for a given block count per stage
//   stage_ctrl_t : per-stage control record (valid, carry out, signed overflow)
package csa_pkg;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned num_blocks(input int unsigned width,
                                               input int unsigned blk);
        return ceil_div(width, blk);
    endfunction

    function automatic int unsigned num_stages(input int unsigned width,
                                               input int unsigned blk,
                                               input int unsigned pipe_blks);
        return ceil_div(num_blocks(width, blk), pipe_blks);
    endfunction

    // carry is the carry leaving the last block resolved so far; ovf is only
    // meaningful in the final stage, which resolves the MSB block.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctrl_t;

endpackage

// File: rtl/csa_block.sv
// One carry-select block: two ripple chains evaluated for an assumed carry-in
// of 0 and of 1, with the real carry-in choosing between them.
//   a_i, b_i  : BW-bit operand slices (b_i already inverted for subtract)
//   cin_i     : real carry into the block
//   sum_o     : BW-bit block sum
//   cout_o    : carry out of the block
//   c_msb_o   : carry into the block's top bit (used for signed overflow)
module csa_block #(
    parameter int unsigned BW = 4
) (
    input  logic [BW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    input  logic          cin_i,
    output logic [BW-1:0] sum_o,
    output logic          cout_o,
    output logic          c_msb_o
);

    logic [BW:0]   c0, c1;
    logic [BW-1:0] s0, s1;

    always_comb begin
        c0    = '0;
        c1    = '0;
        s0    = '0;
        s1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < int'(BW); i++) begin
            s0[i]   = a_i[i] ^ b_i[i] ^ c0[i];
            c0[i+1] = (a_i[i] & b_i[i]) | (c0[i] & (a_i[i] ^ b_i[i]));
            s1[i]   = a_i[i] ^ b_i[i] ^ c1[i];
            c1[i+1] = (a_i[i] & b_i[i]) | (c1[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign sum_o   = cin_i ? s1 : s0;
    assign cout_o  = cin_i ? c1[BW] : c0[BW];
    assign c_msb_o = cin_i ? c1[BW-1] : c0[BW-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_valid / o_ready          : operand handshake
//   i_add_term1, i_add_term2   : operands A and B
//   i_cin                      : carry-in, add mode only
//   i_sub                      : 1 = A - B, 0 = A + B + i_cin
//   o_valid / i_ready          : result handshake
//   sum, cout, overflow        : result, carry out (no-borrow in subtract), signed overflow
// Stage k resolves PIPE_BLKS blocks using the carry registered by stage k-1;
// operands and partial sums travel forward in the stage registers.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned BLK       = 4,
    parameter int unsigned PIPE_BLKS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NB      = num_blocks(WIDTH, BLK);
    localparam int unsigned S       = num_stages(WIDTH, BLK, PIPE_BLKS);
    localparam int unsigned LAST_BW = WIDTH - (NB - 1) * BLK;

    // Sum bits produced by the blocks that stage idx resolves.
    function automatic logic [WIDTH-1:0] stage_mask(input int unsigned idx);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((i / BLK) / PIPE_BLKS == idx) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Stage inputs (from the ports for stage 0, from the previous register otherwise)
    logic [WIDTH-1:0] in_a    [S];
    logic [WIDTH-1:0] in_b    [S];
    logic [WIDTH-1:0] in_sum  [S];
    logic             in_c    [S];
    logic             in_valid[S];

    // Stage results
    logic [WIDTH-1:0] out_sum [S];
    logic             out_c   [S];
    logic             out_ovf [S];

    // Block outputs
    logic [WIDTH-1:0] blk_sum;
    logic             blk_cin  [NB];
    logic             blk_cout [NB];
    logic             last_cmsb;

    // Stage registers
    stage_ctrl_t      ctrl_q [S];
    logic [WIDTH-1:0] a_q    [S];
    logic [WIDTH-1:0] b_q    [S];
    logic [WIDTH-1:0] sum_q  [S];
    logic [S-1:0]     load;

    for (genvar k = 0; k < int'(S); k++) begin : g_stage
        localparam int unsigned KU  = k;
        localparam int unsigned END = ((KU + 1) * PIPE_BLKS < NB) ? (KU + 1) * PIPE_BLKS : NB;
        localparam int unsigned LB  = END - 1;

        if (k == 0) begin : g_first
            assign in_a[k]     = i_add_term1;
            assign in_b[k]     = i_sub ? ~i_add_term2 : i_add_term2;
            assign in_c[k]     = i_sub ? 1'b1 : i_cin;
            assign in_sum[k]   = '0;
            assign in_valid[k] = i_valid;
        end else begin : g_next
            assign in_a[k]     = a_q[k-1];
            assign in_b[k]     = b_q[k-1];
            assign in_c[k]     = ctrl_q[k-1].carry;
            assign in_sum[k]   = sum_q[k-1];
            assign in_valid[k] = ctrl_q[k-1].valid;
        end

        assign out_sum[k] = (in_sum[k] & ~stage_mask(KU)) | (blk_sum & stage_mask(KU));
        assign out_c[k]   = blk_cout[LB];

        if (KU == S - 1) begin : g_ovf
            assign out_ovf[k] = blk_cout[NB-1] ^ last_cmsb;
        end else begin : g_no_ovf
            assign out_ovf[k] = 1'b0;
        end
    end

    for (genvar j = 0; j < int'(NB); j++) begin : g_blk
        localparam int unsigned JU  = j;
        localparam int unsigned BW  = (JU == NB - 1) ? LAST_BW : BLK;
        localparam int unsigned STG = JU / PIPE_BLKS;

        // Only the final block's MSB carry feeds the overflow flag.
        logic msb_carry_unused;

        if (JU % PIPE_BLKS == 0) begin : g_cin_stage
            assign blk_cin[j] = in_c[STG];
        end else begin : g_cin_chain
            assign blk_cin[j] = blk_cout[j-1];
        end

        csa_block #(
            .BW (BW)
        ) u_blk (
            .a_i     (in_a[STG][JU*BLK +: BW]),
            .b_i     (in_b[STG][JU*BLK +: BW]),
            .cin_i   (blk_cin[j]),
            .sum_o   (blk_sum[JU*BLK +: BW]),
            .cout_o  (blk_cout[j]),
            .c_msb_o (msb_carry_unused)
        );

        if (JU == NB - 1) begin : g_last
            assign last_cmsb = msb_carry_unused;
        end
    end

    // A stage may load unless it and every stage after it are full and the
    // consumer is stalling; this is the stall chain unrolled.
    always_comb begin
        load = '0;
        for (int k = 0; k < int'(S); k++) begin
            load[k] = i_ready;
            for (int j = k; j < int'(S); j++) begin
                if (!ctrl_q[j].valid) load[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(S); k++) begin
                ctrl_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                sum_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(S); k++) begin
                if (load[k]) begin
                    ctrl_q[k].valid <= in_valid[k];
                    // Data only moves with a valid op so bubbles leave outputs untouched.
                    if (in_valid[k]) begin
                        ctrl_q[k].carry <= out_c[k];
                        ctrl_q[k].ovf   <= out_ovf[k];
                        a_q[k]          <= in_a[k];
                        b_q[k]          <= in_b[k];
                        sum_q[k]        <= out_sum[k];
                    end
                end
            end
        end
    end

    // The final stage's operand copies have no consumer.
    logic unused_last_ops;
    assign unused_last_ops = ^{a_q[S-1], b_q[S-1]};

    assign o_ready  = load[0];
    assign o_valid  = ctrl_q[S-1].valid;
    assign sum      = sum_q[S-1];
    assign cout     = ctrl_q[S-1].carry;
    assign overflow = ctrl_q[S-1].ovf;

endmodule

// File: tb/tb_csa_pipe_adder.sv
module tb_csa_pipe_adder;

    // Three instances: 16/4/2 (S=2), 5/2/1 (S=3), 8/8/2 (S=1)
    localparam int unsigned WD [3] = '{16, 5, 8};
    localparam int unsigned SD [3] = '{2, 3, 1};

    logic        clk;
    logic        rst_n;
    logic [15:0] opa  [3];
    logic [15:0] opb  [3];
    logic        tv   [3];
    logic        tsub [3];
    logic        tcin [3];
    logic        trdy [3];
    logic        ordy [3];
    logic        ov   [3];
    logic        oc   [3];
    logic        oo   [3];
    logic [17:0] obs  [3];
    logic [15:0] sum0;
    logic [4:0]  sum1;
    logic [7:0]  sum2;

    int nchk = 0;
    int nerr = 0;

    // Scoreboard: expected {overflow, cout, sum} per instance, in acceptance order
    logic [17:0] exp_buf [3][64];
    int          wr [3];
    int          rd [3];
    logic        stalled [3];
    logic [17:0] held [3];

    csa_pipe_adder #(.WIDTH(16), .BLK(4), .PIPE_BLKS(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_valid(tv[0]), .o_ready(ordy[0]),
        .i_add_term1(opa[0]), .i_add_term2(opb[0]), .i_cin(tcin[0]), .i_sub(tsub[0]),
        .o_valid(ov[0]), .i_ready(trdy[0]), .sum(sum0), .cout(oc[0]), .overflow(oo[0])
    );

    csa_pipe_adder #(.WIDTH(5), .BLK(2), .PIPE_BLKS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(tv[1]), .o_ready(ordy[1]),
        .i_add_term1(opa[1][4:0]), .i_add_term2(opb[1][4:0]), .i_cin(tcin[1]),
        .i_sub(tsub[1]), .o_valid(ov[1]), .i_ready(trdy[1]), .sum(sum1), .cout(oc[1]),
        .overflow(oo[1])
    );

    csa_pipe_adder #(.WIDTH(8), .BLK(8), .PIPE_BLKS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(tv[2]), .o_ready(ordy[2]),
        .i_add_term1(opa[2][7:0]), .i_add_term2(opb[2][7:0]), .i_cin(tcin[2]),
        .i_sub(tsub[2]), .o_valid(ov[2]), .i_ready(trdy[2]), .sum(sum2), .cout(oc[2]),
        .overflow(oo[2])
    );

    assign obs[0] = {oo[0], oc[0], sum0};
    assign obs[1] = {oo[1], oc[1], 11'd0, sum1};
    assign obs[2] = {oo[2], oc[2], 8'd0, sum2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, nchk=%0d", nchk);
        $fatal(1, "watchdog");
    end

    // Plain-arithmetic reference: {overflow, cout, sum} for a w-bit operation
    function automatic logic [17:0] model(input int unsigned w, input logic [15:0] a,
                                          input logic [15:0] b, input logic sub,
                                          input logic cin);
        longint unsigned m, aa, bb, full, s;
        logic co, ovf, sa, sb, ss;
        m    = (64'd1 << w) - 64'd1;
        aa   = 64'(a) & m;
        bb   = (sub ? ~64'(b) : 64'(b)) & m;
        full = aa + bb + (sub ? 64'd1 : 64'(cin));
        s    = full & m;
        co   = ((full >> w) & 64'd1) != 0;
        sa   = ((aa >> (w - 1)) & 64'd1) != 0;
        sb   = ((bb >> (w - 1)) & 64'd1) != 0;
        ss   = ((s >> (w - 1)) & 64'd1) != 0;
        ovf  = (sa == sb) && (ss != sa);
        return {ovf, co, 16'(s)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    // Compare process: sampled mid-cycle, transfers take effect at the next rising edge
    initial begin
        for (int d = 0; d < 3; d++) begin
            wr[d] = 0; rd[d] = 0; stalled[d] = 1'b0; held[d] = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < 3; d++) begin
                    wr[d] = 0; rd[d] = 0; stalled[d] = 1'b0;
                end
            end else begin
                for (int d = 0; d < 3; d++) begin
                    if (stalled[d]) begin
                        chk($sformatf("hold_valid[%0d]", d), 32'(ov[d]), 32'd1);
                        chk($sformatf("hold_data[%0d]", d), 32'(obs[d]), 32'(held[d]));
                    end
                    if (ov[d] && trdy[d]) begin
                        if (rd[d] == wr[d]) begin
                            chk($sformatf("spurious_out[%0d]", d), 32'(ov[d]), 32'd0);
                        end else begin
                            chk($sformatf("result[%0d]#%0d", d, rd[d]), 32'(obs[d]),
                                32'(exp_buf[d][rd[d] % 64]));
                            rd[d]++;
                        end
                    end
                    stalled[d] = ov[d] && !trdy[d];
                    held[d]    = obs[d];
                    if (tv[d] && ordy[d]) begin
                        exp_buf[d][wr[d] % 64] = model(WD[d], opa[d], opb[d], tsub[d], tcin[d]);
                        wr[d]++;
                    end
                end
            end
        end
    end

    // Called at posedge+1 with an empty pipe and trdy high; checks exact latency.
    task automatic run_one(input int d, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic cin, input logic [17:0] expv,
                           input string nm);
        opa[d] = a; opb[d] = b; tsub[d] = sub; tcin[d] = cin; tv[d] = 1'b1;
        chk({nm, "_ready"}, 32'(ordy[d]), 32'd1);
        @(posedge clk); #1;
        tv[d] = 1'b0;
        for (int k = 1; k < int'(SD[d]); k++) begin
            chk({nm, "_early"}, 32'(ov[d]), 32'd0);
            @(posedge clk); #1;
        end
        chk({nm, "_valid"}, 32'(ov[d]), 32'd1);
        chk(nm, 32'(obs[d]), 32'(expv));
    endtask

    // Called at posedge+1; holds the op until accepted, optionally randomising i_ready.
    task automatic push_op(input int d, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic cin, input bit rnd);
        logic acc;
        bit   done;
        done = 1'b0;
        opa[d] = a; opb[d] = b; tsub[d] = sub; tcin[d] = cin; tv[d] = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            if (rnd) trdy[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ordy[d];
            @(posedge clk); #1;
            done = acc;
        end
        tv[d] = 1'b0;
        if (!done) chk($sformatf("accept_timeout[%0d]", d), 32'(done), 32'd1);
    endtask

    task automatic drain(input int d);
        trdy[d] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk($sformatf("drained[%0d]", d), 32'(rd[d]), 32'(wr[d]));
        chk($sformatf("drained_valid[%0d]", d), 32'(ov[d]), 32'd0);
    endtask

    initial begin
        logic [17:0] head_exp;
        logic        acc;
        bit          done;
        logic [15:0] a, b;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            opa[d] = '0; opb[d] = '0; tv[d] = 1'b0; tsub[d] = 1'b0; tcin[d] = 1'b0;
            trdy[d] = 1'b1;
        end
        #3;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_valid[%0d]", d), 32'(ov[d]), 32'd0);
            chk($sformatf("reset_data[%0d]", d), 32'(obs[d]), 32'd0);
            chk($sformatf("reset_ready[%0d]", d), 32'(ordy[d]), 32'd1);
        end

        // Pin the reference model with hand-computed values
        chk("model_add_wrap", 32'(model(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);
        chk("model_add_ovf", 32'(model(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h28000);
        chk("model_sub", 32'(model(16, 16'h0005, 16'h0007, 1'b1, 1'b0)), 32'h0FFFE);
        chk("model_s1", 32'(model(8, 16'h0080, 16'h0080, 1'b0, 1'b0)), 32'h30000);
        chk("model_w5_cin", 32'(model(5, 16'h000F, 16'h0000, 1'b0, 1'b1)), 32'h20010);

        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed, 16-bit two-stage instance
        run_one(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000, "add_wrap");
        run_one(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000, "add_ovf");
        run_one(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 18'h0FFFE, "sub_borrow");
        run_one(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFE, "sub_cin_ignored");
        run_one(0, 16'h1234, 16'h1111, 1'b1, 1'b0, 18'h10123, "sub_no_borrow");
        run_one(0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 18'h00100, "add_cin");
        drain(0);

        // Backpressure: four back-to-back ops with the consumer stalled
        trdy[0] = 1'b0;
        head_exp = '0;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            opa[0] = a; opb[0] = b; tsub[0] = i[0]; tcin[0] = i[1]; tv[0] = 1'b1;
            if (i == 0) head_exp = model(16, a, b, i[0], i[1]);
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                @(negedge clk);
                acc = ordy[0];
                if (i == 2 && t == 0) begin
                    chk("bp_ready_low", 32'(ordy[0]), 32'd0);
                    chk("bp_head_valid", 32'(ov[0]), 32'd1);
                    chk("bp_head_data", 32'(obs[0]), 32'(head_exp));
                end
                @(posedge clk); #1;
                done = acc;
                if (i == 2 && t == 3) trdy[0] = 1'b1;
            end
            if (!done) chk("bp_accept_timeout", 32'(done), 32'd1);
        end
        tv[0] = 1'b0;
        drain(0);

        // Random traffic with random backpressure on the 16-bit and S=1 instances
        for (int n = 0; n < 200; n++) begin
            push_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        drain(0);

        run_one(2, 16'h0080, 16'h0080, 1'b0, 1'b0, 18'h30000, "s1_add_ovf");
        for (int n = 0; n < 100; n++) begin
            push_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        drain(2);

        // Non-divisible 5-bit instance: latency, then exhaustive operands and modes
        run_one(1, 16'h0003, 16'h0004, 1'b0, 1'b0, 18'h00007, "w5_latency");
        for (int ai = 0; ai < 32; ai++) begin
            for (int bi = 0; bi < 32; bi++) begin
                for (int m = 0; m < 4; m++) begin
                    push_op(1, 16'(ai), 16'(bi), m[1], m[0], 1'b1);
                end
            end
        end
        drain(1);
        chk("w5_count", 32'(wr[1]), 32'd4097);

        // Asynchronous reset with two ops in flight
        trdy[0] = 1'b0;
        opa[0] = 16'h1234; opb[0] = 16'h1111; tsub[0] = 1'b0; tcin[0] = 1'b0; tv[0] = 1'b1;
        @(posedge clk); #1;
        opa[0] = 16'h0F0F; opb[0] = 16'h0101;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        chk("pre_reset_valid", 32'(ov[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 32'(ov[0]), 32'd0);
        chk("mid_reset_data", 32'(obs[0]), 32'd0);
        chk("mid_reset_ready", 32'(ordy[0]), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        trdy[0] = 1'b1;
        @(posedge clk); #1;
        run_one(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 18'h00007, "post_reset");
        drain(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake. It supersedes the fixed-width combinational carry-select adders in the adder library. Width, carry-select block size and pipeline depth are all configurable, and it adds subtract mode, carry-in and signed overflow. It sits between operand-producing logic and any consumer that can apply backpressure, and sustains one operation per cycle.

## Interface
- WIDTH, 16, operand/sum width in bits (≥ 2)
- BLK, 4, bits per carry-select block (1 ≤ BLK ≤ WIDTH); NB = ceil(WIDTH/BLK) blocks, last block holds WIDTH − (NB−1)·BLK bits
- PIPE_BLKS, 2, blocks evaluated per pipeline stage (≥ 1); S = ceil(NB/PIPE_BLKS) stages
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; one clock, asynchronous, active-low
- i_valid  input  1  operand transfer request
- o_ready  output  1  adder can accept operands this cycle
- i_add_term1  input  WIDTH  operand A
- i_add_term2  input  WIDTH  operand B
- i_cin  input  1  carry-in (add mode only)
- i_sub  input  1  1 = A − B, 0 = A + B + i_cin
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result
- cout  output  1  carry out (in subtract mode: 1 = no borrow, i.e. A ≥ B unsigned)
- overflow  output  1  two's-complement signed overflow

## Operation
- Effective operand B' = i_sub ? ~B : B; carry-in c0 = i_sub ? 1 : i_cin.
- Each block computes sum/carry for assumed carry 0 and carry 1 in parallel. A mux selects the pair using the incoming carry.
- Stage k (1..S) resolves blocks (k−1)·PIPE_BLKS … min(k·PIPE_BLKS, NB)−1, using the carry registered from stage k−1 (c0 for stage 1).
- Unresolved operand bits and already-resolved sum bits travel forward in the stage registers. Stage S drives sum, cout and overflow directly from its registers.
- overflow = carry into MSB XOR carry out of MSB.
- Transfer in occurs when i_valid && o_ready. Transfer out occurs when o_valid && i_ready.
- Per-stage valid bit v[k]. Stage k loads when !v[k] || stage k+1 loads; stage S+1 "loads" means i_ready.
- o_ready = !v[1] || stage 2 loads. This is combinational from i_ready through the stall chain; there is no skid buffer.
- Capacity is S operations in flight. No reordering and no drops, except on reset.

## Timing
- Reset (rst_n low, async): every v[k] = 0 and all data registers = 0. Outputs during reset: o_valid = 0, sum = 0, cout = 0, overflow = 0, o_ready = 1.
- Latency: an operand accepted at edge n gives o_valid = 1 after edge n+S−1, when there is no stall. For S = 1 the result is registered once and is visible the cycle after acceptance.
- Throughput: 1 per cycle when i_ready is held high.
- Stall: while o_valid && !i_ready, sum, cout and overflow are held stable. Upstream stages fill bubbles, and o_ready falls only when every stage is valid.
- Simultaneous in/out with a full pipe: accepted that same cycle, because o_ready stays high when i_ready is high.
- Reset asserted mid-operation: all in-flight results are discarded immediately. After rst_n deasserts, the first acceptance is possible on the next edge.
- i_cin is ignored when i_sub = 1.
- Wrap-around: sum is modulo 2^WIDTH. The carry beyond the MSB is reported only on cout.

## Structure
- Package csa_pkg: function ceil_div(a, b); localparam-style helpers for NB and S; a typedef for the per-stage carry/valid record.
- Sub-module csa_block (parameter BW): BW-bit block, two ripple chains plus select mux; outputs sum[BW−1:0], cout, and carry into MSB (used for overflow in the final block).
- The top level instantiates NB csa_block instances inside a generate loop and builds S stage registers.

## Test plan
- WIDTH=16, BLK=4, PIPE_BLKS=2 (S=2): A=0xFFFF, B=0x0001, add, cin=0 → after 2 edges sum=0x0000, cout=1, overflow=0.
- Same config: A=0x7FFF, B=0x0001, add → sum=0x8000, cout=0, overflow=1. Then A=0x0005, B=0x0007, sub → sum=0xFFFE, cout=0, overflow=0.
- Backpressure: stream 4 operations back-to-back with i_ready=0 → o_ready drops after 2 accepts, and sum stays stable. Raise i_ready → results emerge in order, one per cycle, with none lost or duplicated.
- Reset mid-stream: 2 operations in flight, pulse rst_n low asynchronously between edges → o_valid=0 and sum=0 at once. After release, a new operation A=3, B=4 → sum=7.
- Non-divisible config WIDTH=5, BLK=2, PIPE_BLKS=1 (NB=3, S=3): exhaustive A, B, i_sub, i_cin against a reference model, with random i_ready → all results match, latency is 3 when unstalled.
- S=1 config (WIDTH=8, BLK=8): A=0x80, B=0x80, add → sum=0x00, cout=1, overflow=1, one cycle after accept.
